ldlatch: RTL and testbench
==========================

LDLATCH -- requirements
Module: ldlatch

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, all state on rising edge
- resetl  in  1  asynchronous active-low reset
- ldreq  in  1  load request strobe, sampled when idle
- ldsize  in  2  00=byte, 01=word (16b), 10=long (32b), 11=reserved
- ldaddr0  in  1  byte-lane select for byte loads (0=high byte, big-endian)
- abort  in  1  cancel the current load
- bdata  in  16  bus read data
- back  in  1  bus data acknowledge, bdata valid this cycle
- breq  out  1  bus read request
- bhilo  out  1  phase being requested (1=high/first word, 0=low/second word)
- ldbusy  out  1  load in progress
- lddone  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  assembled, zero-extended load result

Function
REQ-003 The block SHALL implement states IDLE, WAIT_HI, WAIT_LO and DONE.
REQ-004 IDLE + ldreq=1 + ldsize in {00,01,10} SHALL latch ldsize/ldaddr0 and go to WAIT_HI next cycle.
REQ-005 IDLE + ldreq=1 + ldsize=11 SHALL be ignored: no state change, no bus request.
REQ-006 breq SHALL be 1 in WAIT_HI and WAIT_LO, and 0 in every other state.
REQ-007 bhilo SHALL be 1 in WAIT_HI and 0 otherwise.
REQ-008 WAIT_HI + back=1 SHALL capture bdata into the high holding word; for a long load the next state is WAIT_LO, otherwise DONE.
REQ-009 WAIT_LO + back=1 SHALL capture bdata into the low holding word; the next state is DONE.
REQ-010 Without back, a WAIT state SHALL hold indefinitely, with breq held at 1.
REQ-011 DONE SHALL last exactly one cycle: lddone=1, then IDLE.
REQ-012 ld_data SHALL be registered and SHALL be updated on entry to DONE:
- long: {hi, lo}
- word: {16'h0, hi}
- byte: {24'h0, ldaddr0 ? hi[7:0] : hi[15:8]}
REQ-013 ld_data SHALL hold its value until the next DONE; it is not cleared on IDLE or abort.
REQ-014 ldbusy SHALL be 1 in WAIT_HI, WAIT_LO and DONE.
REQ-015 Minimum latency from ldreq to lddone SHALL be:
- 3 cycles for byte/word when back arrives in the first WAIT cycle
- 4 cycles for long
REQ-016 ldreq while ldbusy=1 SHALL be ignored; it is not queued.
REQ-017 back while in IDLE or DONE SHALL be ignored.
REQ-018 abort=1 in WAIT_HI or WAIT_LO SHALL go to IDLE next cycle, with no lddone and no ld_data update. Abort wins over a simultaneous back.
REQ-019 abort in IDLE or DONE SHALL have no effect; a DONE pulse still completes.
REQ-020 Holding words SHALL update only on an accepted back, and hold otherwise (mux-feedback register).

Reset
REQ-021 resetl=0 SHALL immediately force all of the following, regardless of clk, including mid-load:
- state=IDLE
- breq=0, bhilo=0, ldbusy=0, lddone=0
- ld_data=32'h0
- holding words=16'h0
- latched size/addr=0
REQ-022 The first ldreq after resetl deasserts SHALL be honoured on the first rising edge at which resetl=1.

Structure
REQ-023 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_WORD, SZ_LONG, SZ_RSVD) and the state encoding constants.
REQ-024 The 16-bit hold-enable register SHALL be one sub-module, ldword (ports clk, resetl, en, d[15:0], q[15:0]: q loads d when en=1, else holds). It SHALL be instantiated twice, for the high and low words.
REQ-025 The FSM, breq/bhilo decode and ld_data formatting SHALL live in ldlatch itself.

Verification
REQ-026 Long load: ldreq, ldsize=10; back with bdata=16'h1234 in cycle 2, then 16'h5678 in cycle 3 -> lddone in cycle 4, ld_data=32'h12345678, bhilo 1 then 0.
REQ-027 Byte load: ldsize=00, ldaddr0=1, back with bdata=16'hABCD -> ld_data=32'h000000CD; repeated with ldaddr0=0 -> 32'h000000AB.
REQ-028 Wait states: word load with back delayed 5 cycles, bdata=16'hBEEF -> breq=1 for 6 cycles, then ld_data=32'h0000BEEF, lddone exactly one cycle.
REQ-029 Abort: long load, abort coincident with the second back -> no lddone, ld_data keeps its previous value, state IDLE; the next load completes normally.
REQ-030 Reset mid-load: resetl=0 in WAIT_LO -> breq, ldbusy and ld_data are 0 immediately; stray back in IDLE -> no effect.
REQ-031 Ignored requests: ldreq while busy and ldsize=11 in IDLE -> no extra lddone, breq stays 0 for the reserved size.

Source files
------------

// File: rtl/ldlatch_pkg.sv
// Shared encodings for the ldlatch bus-load sequencer.
package ldlatch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_RSVD = 2'b11
  } ldsize_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_WAIT_LO = 2'b10,
    ST_DONE    = 2'b11
  } ldstate_e;

endpackage

// File: rtl/ldword.sv
// 16-bit hold-enable register: loads d when en, otherwise keeps its value.
module ldword
  import ldlatch_pkg::*;
(
  input  logic              clk,
  input  logic              resetl,
  input  logic              en,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ldlatch.sv
// Big-endian load sequencer: fetches one or two 16-bit bus words and
// assembles a zero-extended 32-bit result.
module ldlatch
  import ldlatch_pkg::*;
(
  input  logic              clk,
  input  logic              resetl,
  input  logic              ldreq,
  input  logic [1:0]        ldsize,
  input  logic              ldaddr0,
  input  logic              abort,
  input  logic [WORD_W-1:0] bdata,
  input  logic              back,
  output logic              breq,
  output logic              bhilo,
  output logic              ldbusy,
  output logic              lddone,
  output logic [DATA_W-1:0] ld_data
);

  ldstate_e          state, state_n;
  ldsize_e           size_q;
  logic              addr0_q;
  logic              req_acc;
  logic              hi_en, lo_en, data_en;
  logic [WORD_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] data_n;

  ldword u_hi (.clk(clk), .resetl(resetl), .en(hi_en), .d(bdata), .q(hi_q));
  ldword u_lo (.clk(clk), .resetl(resetl), .en(lo_en), .d(bdata), .q(lo_q));

  // State register
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next state, holding-word enables and result formatting
  always_comb begin
    state_n = state;
    req_acc = 1'b0;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    data_en = 1'b0;
    data_n  = ld_data;
    case (state)
      ST_IDLE: begin
        if (ldreq && (ldsize_e'(ldsize) != SZ_RSVD)) begin
          req_acc = 1'b1;
          state_n = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (back) begin
          hi_en = 1'b1;
          if (size_q == SZ_LONG) begin
            state_n = ST_WAIT_LO;
          end else begin
            state_n = ST_DONE;
            data_en = 1'b1;
            if (size_q == SZ_WORD) data_n = {16'h0, bdata};
            else data_n = {24'h0, (addr0_q ? bdata[7:0] : bdata[15:8])};
          end
        end
      end
      ST_WAIT_LO: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (back) begin
          lo_en   = 1'b1;
          state_n = ST_DONE;
          data_en = 1'b1;
          data_n  = {hi_q, bdata};
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Request attributes held for the whole load
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      size_q  <= SZ_BYTE;
      addr0_q <= 1'b0;
    end else if (req_acc) begin
      size_q  <= ldsize_e'(ldsize);
      addr0_q <= ldaddr0;
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      breq    <= 1'b0;
      bhilo   <= 1'b0;
      ldbusy  <= 1'b0;
      lddone  <= 1'b0;
      ld_data <= '0;
    end else begin
      breq   <= (state_n == ST_WAIT_HI) || (state_n == ST_WAIT_LO);
      bhilo  <= (state_n == ST_WAIT_HI);
      ldbusy <= (state_n != ST_IDLE);
      lddone <= (state_n == ST_DONE);
      if (data_en) ld_data <= data_n;
    end
  end

endmodule

// File: tb/tb_ldlatch.sv
// Directed self-checking bench for ldlatch.
module tb_ldlatch;

  logic        clk = 1'b0;
  logic        resetl;
  logic        ldreq;
  logic [1:0]  ldsize;
  logic        ldaddr0;
  logic        abort;
  logic [15:0] bdata;
  logic        back;
  logic        breq, bhilo, ldbusy, lddone;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  ldlatch dut (
    .clk(clk), .resetl(resetl), .ldreq(ldreq), .ldsize(ldsize),
    .ldaddr0(ldaddr0), .abort(abort), .bdata(bdata), .back(back),
    .breq(breq), .bhilo(bhilo), .ldbusy(ldbusy), .lddone(lddone),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; state is WAIT_HI afterwards
  task automatic req(input logic [1:0] sz, input logic a0);
    ldreq = 1'b1; ldsize = sz; ldaddr0 = a0;
    tick();
    ldreq = 1'b0;
  endtask

  task automatic ack(input logic [15:0] w);
    back = 1'b1; bdata = w;
    tick();
    back = 1'b0;
  endtask

  initial begin
    resetl = 1'b0; ldreq = 1'b0; ldsize = 2'b00; ldaddr0 = 1'b0;
    abort = 1'b0; bdata = 16'h0; back = 1'b0;
    tick(); tick();
    chk("rst_breq", 32'(breq), 32'd0);
    chk("rst_bhilo", 32'(bhilo), 32'd0);
    chk("rst_busy", 32'(ldbusy), 32'd0);
    chk("rst_done", 32'(lddone), 32'd0);
    chk("rst_data", ld_data, 32'h0);
    resetl = 1'b1;
    tick();

    // Long load
    req(2'b10, 1'b0);
    chk("long_breq_hi", 32'(breq), 32'd1);
    chk("long_bhilo_hi", 32'(bhilo), 32'd1);
    chk("long_busy", 32'(ldbusy), 32'd1);
    ack(16'h1234);
    chk("long_breq_lo", 32'(breq), 32'd1);
    chk("long_bhilo_lo", 32'(bhilo), 32'd0);
    chk("long_nodone", 32'(lddone), 32'd0);
    ack(16'h5678);
    chk("long_done", 32'(lddone), 32'd1);
    chk("long_data", ld_data, 32'h12345678);
    chk("long_done_breq", 32'(breq), 32'd0);
    chk("long_done_busy", 32'(ldbusy), 32'd1);
    tick();
    chk("long_idle_done", 32'(lddone), 32'd0);
    chk("long_idle_busy", 32'(ldbusy), 32'd0);
    chk("long_hold", ld_data, 32'h12345678);

    // Byte loads, both lanes
    req(2'b00, 1'b1);
    ack(16'hABCD);
    chk("byte1_done", 32'(lddone), 32'd1);
    chk("byte1_data", ld_data, 32'h000000CD);
    tick();
    req(2'b00, 1'b0);
    ack(16'hABCD);
    chk("byte0_done", 32'(lddone), 32'd1);
    chk("byte0_data", ld_data, 32'h000000AB);
    tick();

    // Word load with five wait cycles; breq seen for six cycles
    req(2'b01, 1'b0);
    begin
      int breq_cnt = 0;
      for (int i = 0; i < 5; i++) begin
        if (breq) breq_cnt++;
        tick();
      end
      if (breq) breq_cnt++;
      ack(16'hBEEF);
      chk("wait_breq_cycles", 32'(breq_cnt), 32'd6);
    end
    chk("wait_done", 32'(lddone), 32'd1);
    chk("wait_data", ld_data, 32'h0000BEEF);
    chk("wait_breq_off", 32'(breq), 32'd0);
    tick();
    chk("wait_done_pulse", 32'(lddone), 32'd0);

    // Abort wins over coincident second back
    req(2'b10, 1'b0);
    ack(16'h1111);
    abort = 1'b1;
    ack(16'h2222);
    abort = 1'b0;
    chk("abort_nodone", 32'(lddone), 32'd0);
    chk("abort_busy", 32'(ldbusy), 32'd0);
    chk("abort_breq", 32'(breq), 32'd0);
    chk("abort_data", ld_data, 32'h0000BEEF);
    tick();
    chk("abort_nodone2", 32'(lddone), 32'd0);
    req(2'b10, 1'b0);
    ack(16'hCAFE);
    ack(16'hF00D);
    chk("post_abort_done", 32'(lddone), 32'd1);
    chk("post_abort_data", ld_data, 32'hCAFEF00D);
    tick();

    // Reset in WAIT_LO clears outputs without a clock edge
    req(2'b10, 1'b0);
    ack(16'h9999);
    #2 resetl = 1'b0;
    #1;
    chk("mrst_breq", 32'(breq), 32'd0);
    chk("mrst_busy", 32'(ldbusy), 32'd0);
    chk("mrst_data", ld_data, 32'h0);
    tick();
    resetl = 1'b1;
    ack(16'hFFFF);
    chk("stray_breq", 32'(breq), 32'd0);
    chk("stray_busy", 32'(ldbusy), 32'd0);
    tick();
    chk("stray_done", 32'(lddone), 32'd0);
    chk("stray_data", ld_data, 32'h0);

    // Request present as reset releases is taken on the first edge
    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    req(2'b00, 1'b1);
    chk("rel_breq", 32'(breq), 32'd1);
    ack(16'h5AA5);
    chk("rel_data", ld_data, 32'h000000A5);
    tick();

    // ldreq while busy is not queued; reserved size ignored
    req(2'b01, 1'b0);
    ldreq = 1'b1;
    ack(16'h0042);
    chk("busy_done", 32'(lddone), 32'd1);
    tick();
    ldreq = 1'b0;
    chk("busy_noreq_breq", 32'(breq), 32'd0);
    tick();
    chk("busy_no_extra", 32'(lddone), 32'd0);
    chk("busy_data", ld_data, 32'h00000042);
    req(2'b11, 1'b0);
    chk("rsvd_breq", 32'(breq), 32'd0);
    chk("rsvd_busy", 32'(ldbusy), 32'd0);
    tick();
    chk("rsvd_done", 32'(lddone), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
